// File: rtl/spi_flash_slv_pkg.sv
// Shared types and constants for the SPI flash responder: FSM states,
// command opcodes and bit-counter limits.
package spi_flash_slv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    FETCH,
    DATA,
    IGNORE
  } state_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int ADDR_BITS = 24;
  localparam int BIT_CNT_W = 5;

  localparam logic [BIT_CNT_W-1:0] LAST_CMD_BIT   = 5'd7;
  localparam logic [BIT_CNT_W-1:0] LAST_ADDR_BIT  = 5'd23;
  localparam logic [BIT_CNT_W-1:0] LAST_DUMMY_BIT = 5'd7;

endpackage

// File: rtl/spi_slv_sync_edge.sv
// Brings spi_clk/spi_cs/spi_mosi into the clk domain through equal-depth
// synchronizer chains and flags rising/falling edges of the synced SPI clock.
module spi_slv_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;

  // CS chain resets to "selected" so a CS held low across reset never looks
  // like a fresh high-to-low select.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes the chain a chain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;

endmodule

// File: rtl/spi_flash_slave.sv
// SPI NOR-flash READ responder backed by a 1-cycle-latency word memory.
// Define SPI_FLASH_SLV_FAST_READ_EN to also accept FAST READ (0x0B, 8 dummy clocks).
module spi_flash_slave
  import spi_flash_slv_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MEM_AW      = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              cmd_err
);

  logic cs_n_s, mosi_s, sclk_rise, sclk_fall;

  spi_slv_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi),
    .cs_n_s   (cs_n_s),
    .mosi_s   (mosi_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall)
  );

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]            word_q, word_d;
  logic [31:0]            nxt_word_q, nxt_word_d;
  logic                   rsp_vld_q, rsp_vld_d;
  logic                   armed_q, armed_d;
  logic                   miso_q, miso_d;
  logic                   mem_req_q, mem_req_d;
  logic [MEM_AW-1:0]      mem_addr_q, mem_addr_d;
  logic                   cmd_err_q, cmd_err_d;

  logic [7:0]           cmd_shift;
  logic [ADDR_BITS-1:0] addr_shift;
  logic [ADDR_BITS-1:0] addr_inc;

  assign cmd_shift  = {cmd_q[6:0], mosi_s};
  assign addr_shift = {addr_q[ADDR_BITS-2:0], mosi_s};
  assign addr_inc   = addr_q + 24'd1;

  // NOTE: every _d gets a default first, so no path through the case leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    word_d     = word_q;
    nxt_word_d = nxt_word_q;
    rsp_vld_d  = mem_req_q;
    armed_d    = armed_q;
    miso_d     = miso_q;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    cmd_err_d  = 1'b0;

    if (cs_n_s) begin
      // Deselect beats any coincident SPI edge and drops an in-flight response.
      state_d   = IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b1;
      rsp_vld_d = 1'b0;
      armed_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (armed_q) begin
          state_d   = CMD;
          bit_cnt_d = '0;
        end
        CMD: if (sclk_rise) begin
          cmd_d     = cmd_shift;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == LAST_CMD_BIT) begin
            bit_cnt_d = '0;
            if (cmd_shift == CMD_READ) state_d = ADDR;
`ifdef SPI_FLASH_SLV_FAST_READ_EN
            else if (cmd_shift == CMD_FAST_READ) state_d = ADDR;
`endif
            else begin
              state_d   = IGNORE;
              cmd_err_d = 1'b1;
            end
          end
        end
        ADDR: if (sclk_rise) begin
          addr_d    = addr_shift;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == LAST_ADDR_BIT) begin
            bit_cnt_d = '0;
`ifdef SPI_FLASH_SLV_FAST_READ_EN
            if (cmd_q == CMD_FAST_READ) state_d = DUMMY;
            else begin
              state_d    = FETCH;
              mem_req_d  = 1'b1;
              mem_addr_d = {addr_shift[MEM_AW-1:2], 2'b00};
            end
`else
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = {addr_shift[MEM_AW-1:2], 2'b00};
`endif
          end
        end
        DUMMY: if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == LAST_DUMMY_BIT) begin
            bit_cnt_d  = '0;
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = {addr_q[MEM_AW-1:2], 2'b00};
          end
        end
        FETCH: if (rsp_vld_q) begin
          word_d  = mem_rdata;
          state_d = DATA;
        end
        DATA: begin
          if (rsp_vld_q) nxt_word_d = mem_rdata;
          if (sclk_fall) begin
            // Byte lane addr[1:0], MSB first: bit index {lane, 7-bit_cnt}.
            miso_d    = word_q[{addr_q[1:0], ~bit_cnt_q[2:0]}];
            bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
            if (bit_cnt_q[2:0] == 3'd0 && addr_q[1:0] == 2'd3) begin
              mem_req_d  = 1'b1;
              mem_addr_d = {addr_inc[MEM_AW-1:2], 2'b00};
            end
            if (bit_cnt_q[2:0] == 3'd7) begin
              addr_d = addr_inc;
              if (addr_q[1:0] == 2'd3) word_d = nxt_word_q;
            end
          end
        end
        IGNORE: miso_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the data/word registers are reset along with the control state; it
  // is only a few flops here and keeps X off MISO after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      nxt_word_q <= '0;
      rsp_vld_q  <= 1'b0;
      armed_q    <= 1'b0;
      miso_q     <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      nxt_word_q <= nxt_word_d;
      rsp_vld_q  <= rsp_vld_d;
      armed_q    <= armed_d;
      miso_q     <= miso_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign spi_miso = miso_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign cmd_err  = cmd_err_q;

endmodule
